// File: rtl/regfile_2r1w_clr.sv
// Two-read / one-write register file with registered reads, write-to-read bypass and a post-reset clear sequencer.
// Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero (writes dropped, reads return 0, no bypass).
module regfile_2r1w_clr #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2,
    output logic              ready
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic             w_waddr_ok;
    logic             w_raddr1_ok;
    logic             w_raddr2_ok;
    logic             w_wr_ok;
    logic [WIDTH-1:0] w_rd1_nxt;
    logic [WIDTH-1:0] w_rd2_nxt;

    assign w_waddr_ok  = {1'b0, waddr}  < LP_DEPTH;
    assign w_raddr1_ok = {1'b0, raddr1} < LP_DEPTH;
    assign w_raddr2_ok = {1'b0, raddr2} < LP_DEPTH;

`ifdef REGFILE_ZERO_REG_EN
    assign w_wr_ok = we && w_waddr_ok && (waddr != '0);
`else
    assign w_wr_ok = we && w_waddr_ok;
`endif

    // Bypass only matches in-range write addresses, so an out-of-range read never sees wdata.
    always_comb begin
        w_rd1_nxt = '0;
        if (w_raddr1_ok) begin
            if (w_wr_ok && (waddr == raddr1)) begin
                w_rd1_nxt = wdata;
            end else begin
                w_rd1_nxt = r_mem[raddr1];
            end
        end
`ifdef REGFILE_ZERO_REG_EN
        if (raddr1 == '0) begin
            w_rd1_nxt = '0;
        end
`endif
    end

    always_comb begin
        w_rd2_nxt = '0;
        if (w_raddr2_ok) begin
            if (w_wr_ok && (waddr == raddr2)) begin
                w_rd2_nxt = wdata;
            end else begin
                w_rd2_nxt = r_mem[raddr2];
            end
        end
`ifdef REGFILE_ZERO_REG_EN
        if (raddr2 == '0) begin
            w_rd2_nxt = '0;
        end
`endif
    end

    // Storage has no reset; the clear sequencer owns the write port until ready rises.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_wr_ok) begin
                r_mem[waddr] <= wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            ready     <= 1'b0;
            rdata1    <= '0;
            rdata2    <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == LP_LAST) begin
                        r_state <= S_RUN;
                        ready   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (re1) begin
                        rdata1 <= w_rd1_nxt;
                    end
                    if (re2) begin
                        rdata2 <= w_rd2_nxt;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Bench for regfile_2r1w_clr: a DEPTH=32 and a DEPTH=24 instance share stimulus; a scoreboard queue holds expected read data.
// Honours REGFILE_ZERO_REG_EN for the address-0 expectations.
module tb_regfile_2r1w_clr;

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] b1;
        logic [31:0] b2;
        string       nm;
    } exp_t;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [31:0] Z1234 = 32'h0;
`else
    localparam logic [31:0] Z1234 = 32'h1234;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        rdy_a, rdy_b;

    logic chk   = 1'b0;
    logic chk_d = 1'b0;
    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_2r1w_clr #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rd1_a),
        .re2(re2), .raddr2(raddr2), .rdata2(rd2_a), .ready(rdy_a)
    );

    regfile_2r1w_clr #(.WIDTH(32), .DEPTH(24), .ADDR_W(5)) u_dut24 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rd1_b),
        .re2(re2), .raddr2(raddr2), .rdata2(rd2_b), .ready(rdy_b)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // chk marks the cycle whose edge produces data to observe; results are compared on the following negedge.
    always @(posedge clk) chk_d <= chk;

    always @(negedge clk) begin : mon
        exp_t e;
        if (chk_d) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard: observation with empty queue");
            end else begin
                e = q.pop_front();
                cmp({e.nm, " d32.rdata1"}, rd1_a, e.a1);
                cmp({e.nm, " d32.rdata2"}, rd2_a, e.a2);
                cmp({e.nm, " d24.rdata1"}, rd1_b, e.b1);
                cmp({e.nm, " d24.rdata2"}, rd2_b, e.b2);
            end
        end
    end

    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2,
                        input logic c, input logic [31:0] ea1, input logic [31:0] ea2,
                        input logic [31:0] eb1, input logic [31:0] eb2, input string nm);
        exp_t e;
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
        chk = c;
        if (c) begin
            e.a1 = ea1; e.a2 = ea2; e.b1 = eb1; e.b2 = eb2; e.nm = nm;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        we = 1'b0; re1 = 1'b0; re2 = 1'b0; chk = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    endtask

    task automatic rd2(input logic [4:0] a, input logic [31:0] ea, input logic [31:0] eb, input string nm);
        step(0, 0, 0, 1, a, 1, a, 1, ea, ea, eb, eb, nm);
    endtask

    // Clear phase with both reads enabled; ready must rise after exactly 32 / 24 edges.
    task automatic clear_walk(input string nm);
        for (int k = 1; k <= 34; k++) begin
            step(0, 0, 0, 1, 5'(k), 1, 5'(k + 3), 1, 0, 0, 0, 0, {nm, " rdata during clear"});
            cmp({nm, " ready d32"}, {31'b0, rdy_a}, {31'b0, (k >= 32)});
            cmp({nm, " ready d24"}, {31'b0, rdy_b}, {31'b0, (k >= 24)});
        end
    endtask

    function automatic logic [31:0] exp_at(input int i);
        case (i)
            7:       return 32'hDEADBEEF;
            9:       return 32'h22222222;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        idle();
        cmp("reset d32.rdata1", rd1_a, 0);
        cmp("reset d32.rdata2", rd2_a, 0);
        cmp("reset d24.rdata1", rd1_b, 0);
        cmp("reset d24.rdata2", rd2_b, 0);
        cmp("reset d32.ready", {31'b0, rdy_a}, 0);
        cmp("reset d24.ready", {31'b0, rdy_b}, 0);
        rst = 1'b0;
        clear_walk("init");

        for (int i = 0; i < 32; i++) rd2(5'(i), 0, 0, "post-clear read");

        step(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        step(0, 0, 0, 1, 7, 0, 0, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, "write-read 7");
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, "hold re=0");

        step(1, 9, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        step(1, 9, 32'h22222222, 1, 9, 1, 9, 1, 32'h22222222, 32'h22222222,
             32'h22222222, 32'h22222222, "bypass dual 9");
        rd2(9, 32'h22222222, 32'h22222222, "after bypass 9");

        step(1, 30, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        step(0, 0, 0, 1, 30, 1, 23, 1, 32'hA5A5A5A5, 0, 0, 0, "oor read 30");
        step(1, 31, 32'h0BAD0BAD, 1, 31, 1, 31, 1, 32'h0BAD0BAD, 32'h0BAD0BAD, 0, 0, "oor bypass 31");
        for (int i = 0; i < 24; i++) rd2(5'(i), exp_at(i), exp_at(i), "entries unchanged");

        step(1, 0, 32'h1234, 1, 0, 1, 7, 1, Z1234, 32'hDEADBEEF, Z1234, 32'hDEADBEEF, "zero-reg same-cycle");
        rd2(0, Z1234, Z1234, "zero-reg later read");

        step(1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        rd2(3, 32'h55, 32'h55, "fill 3");
        rst = 1'b1;
        step(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        rst = 1'b0;
        cmp("midrst d32.rdata1", rd1_a, 0);
        cmp("midrst d24.rdata2", rd2_b, 0);
        cmp("midrst d32.ready", {31'b0, rdy_a}, 0);
        cmp("midrst d24.ready", {31'b0, rdy_b}, 0);
        clear_walk("midrst");
        rd2(3, 0, 0, "addr3 after rst");
        rd2(4, 0, 0, "addr4 after rst");

        for (int i = 0; i < 10; i++) idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        clear_walk("reclear");

        idle();
        idle();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
